// File: rtl/acc_register_bank.sv
`default_nettype none
// ============================================================================
//  Module      : acc_register_bank
//  Description : Bank of CHANNELS signed accumulators with LOAD/ADD/SUB/CLEAR
//                ops, optional saturation, sticky overflow and clear-all FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_register_bank #(
    parameter int WORD_LENGTH = 8,
    parameter int CHANNELS    = 4,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      op,
    input  logic [$clog2(CHANNELS)-1:0]     ch_sel,
    input  logic signed [WORD_LENGTH-1:0]   Data_Input,
    input  logic                            clear_all,
    output logic                            busy,
    output logic                            res_valid,
    output logic [$clog2(CHANNELS)-1:0]     res_ch,
    output logic signed [WORD_LENGTH-1:0]   res_data,
    output logic                            res_ovf,
    input  logic [$clog2(CHANNELS)-1:0]     rd_ch,
    output logic signed [WORD_LENGTH-1:0]   rd_data
);

    localparam int                       CH_BITS   = $clog2(CHANNELS);
    localparam logic [CH_BITS:0]         C_NUM_CH  = (CH_BITS+1)'(CHANNELS);
    localparam logic [CH_BITS-1:0]       C_LAST_CH = CH_BITS'(CHANNELS-1);
    localparam logic [WORD_LENGTH-1:0]   C_MAX     = {1'b0, {(WORD_LENGTH-1){1'b1}}};
    localparam logic [WORD_LENGTH-1:0]   C_MIN     = {1'b1, {(WORD_LENGTH-1){1'b0}}};
    localparam logic [1:0]               C_OP_LOAD = 2'b00;
    localparam logic [1:0]               C_OP_ADD  = 2'b01;
    localparam logic [1:0]               C_OP_SUB  = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_CLEARING = 1'b1
    } state_t;

    state_t                         r_state;
    logic [CH_BITS-1:0]             r_cnt;
    logic signed [WORD_LENGTH-1:0]  r_acc [CHANNELS];
    logic [CHANNELS-1:0]            r_ovf;

    logic signed [WORD_LENGTH-1:0]  w_acc_next [CHANNELS];
    logic [CHANNELS-1:0]            w_ovf_next;
    logic                           w_ch_ok;
    logic                           w_rd_ok;
    logic                           w_write;
    logic signed [WORD_LENGTH-1:0]  w_cur;
    logic                           w_cur_ovf;
    logic signed [WORD_LENGTH:0]    w_sum;
    logic                           w_overflow;
    logic signed [WORD_LENGTH-1:0]  w_result;
    logic                           w_new_ovf;

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_CLEARING);
    assign w_ch_ok  = ({1'b0, ch_sel} < C_NUM_CH);
    assign w_rd_ok  = ({1'b0, rd_ch} < C_NUM_CH);
    assign w_write  = in_valid & in_ready & w_ch_ok;

    always_comb begin
        w_cur     = w_ch_ok ? r_acc[ch_sel] : '0;
        w_cur_ovf = w_ch_ok & r_ovf[ch_sel];

        // One extra bit of headroom makes overflow a simple sign-bit disagreement
        if (op == C_OP_SUB) begin
            w_sum = {w_cur[WORD_LENGTH-1], w_cur} - {Data_Input[WORD_LENGTH-1], Data_Input};
        end else begin
            w_sum = {w_cur[WORD_LENGTH-1], w_cur} + {Data_Input[WORD_LENGTH-1], Data_Input};
        end
        w_overflow = w_sum[WORD_LENGTH] ^ w_sum[WORD_LENGTH-1];

        w_result  = '0;
        w_new_ovf = 1'b0;
        case (op)
            C_OP_LOAD: begin
                w_result  = Data_Input;
                w_new_ovf = w_cur_ovf;
            end
            C_OP_ADD, C_OP_SUB: begin
                if (SATURATE && w_overflow) begin
                    w_result = w_sum[WORD_LENGTH] ? C_MIN : C_MAX;
                end else begin
                    w_result = w_sum[WORD_LENGTH-1:0];
                end
                w_new_ovf = w_cur_ovf | w_overflow;
            end
            default: begin
                w_result  = '0;
                w_new_ovf = 1'b0;
            end
        endcase

        for (int i = 0; i < CHANNELS; i++) begin
            w_acc_next[i] = r_acc[i];
        end
        w_ovf_next = r_ovf;

        if (w_write) begin
            w_acc_next[ch_sel] = w_result;
            w_ovf_next[ch_sel] = w_new_ovf;
        end

        // Ops are blocked while clearing, so the sweep never collides with a write
        if (r_state == S_CLEARING) begin
            w_acc_next[r_cnt] = '0;
            w_ovf_next[r_cnt] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_all) begin
                        r_state <= S_CLEARING;
                        r_cnt   <= '0;
                    end
                end
                S_CLEARING: begin
                    if (r_cnt == C_LAST_CH) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf     <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
            rd_data   <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= w_acc_next[i];
            end
            r_ovf     <= w_ovf_next;
            res_valid <= w_write;
            if (w_write) begin
                res_ch   <= ch_sel;
                res_data <= w_result;
                res_ovf  <= w_new_ovf;
            end
            // Write-first: the read sees whatever lands in the bank at this edge
            rd_data <= w_rd_ok ? w_acc_next[rd_ch] : '0;
        end
    end

endmodule
`default_nettype wire
